// File: rtl/stage_latch_hs_if.sv
// Handshake bundle between two pipeline stages: upstream side (in_*) and downstream side (out_*).
// No storage of its own; it only carries wires.
// The master modport drives in_*/out_ready; the slave modport is the stage register itself.
interface stage_latch_hs_if #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 9
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );
endinterface

// File: rtl/stage_latch_hs.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid, flush and profiling counters.
// Latency: 1 cycle from accept to out_valid when empty; strict FIFO order.
// Backpressure: SKID=1 gives in_ready from the state register only; SKID=0 gives in_ready = ~out_valid | out_ready.
module stage_latch_hs #(
    parameter int DATA_W   = 96,
    parameter int CTRL_W   = 9,
    parameter int SKID     = 1,
    parameter int CLR_DATA = 1,
    parameter int CNT_W    = 16
) (
    input  logic             stg_clk,
    input  logic             reset,
    stage_latch_hs_if.slave  hs,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FULL      = 2'd1,
        SKID_FULL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              out_valid;
    logic              in_ready;
    logic              accept;
    logic              drain;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign out_valid = (state_q != EMPTY);
    assign accept    = hs.in_valid & in_ready;
    assign drain     = out_valid & hs.out_ready;

    // Ready decode: registered-only with the skid, pass-through of out_ready without it
    always_comb begin
        in_ready = 1'b1;
        if (SKID != 0) begin
            in_ready = (state_q != SKID_FULL);
        end else begin
            in_ready = ~out_valid | hs.out_ready;
        end
    end

    // Next-state and register loads; flush overrides every transfer
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_data_d = '0;
            skid_ctrl_d = '0;
            if (CLR_DATA != 0) begin
                main_data_d = '0;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_data_d = hs.in_data;
                        main_ctrl_d = hs.in_ctrl;
                        state_d     = FULL;
                    end
                end
                FULL: begin
                    if (accept && drain) begin
                        main_data_d = hs.in_data;
                        main_ctrl_d = hs.in_ctrl;
                    end else if (accept) begin
                        // only reachable with SKID=1: without the skid, accept while full implies drain
                        skid_data_d = hs.in_data;
                        skid_ctrl_d = hs.in_ctrl;
                        state_d     = SKID_FULL;
                    end else if (drain) begin
                        main_ctrl_d = '0;
                        if (CLR_DATA != 0) begin
                            main_data_d = '0;
                        end
                        state_d = EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (drain) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        skid_data_d = '0;
                        skid_ctrl_d = '0;
                        state_d     = FULL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Saturating profiling counters; clear wins over increment
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
            flush_cnt_d  = '0;
        end else begin
            if (out_valid && !hs.out_ready) stall_cnt_d  = sat_inc(stall_cnt_q);
            if (!out_valid && hs.out_ready) bubble_cnt_d = sat_inc(bubble_cnt_q);
            if (flush)                      flush_cnt_d  = sat_inc(flush_cnt_q);
        end
    end

    // State, payload and counter registers
    always_ff @(posedge stg_clk or posedge reset) begin
        if (reset) begin
            state_q      <= EMPTY;
            main_data_q  <= '0;
            main_ctrl_q  <= '0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    // Control bits are masked by valid so a bubble can never carry a write-enable
    assign hs.in_ready  = in_ready;
    assign hs.out_valid = out_valid;
    assign hs.out_data  = main_data_q;
    assign hs.out_ctrl  = main_ctrl_q & {CTRL_W{out_valid}};
    assign stall_cnt    = stall_cnt_q;
    assign bubble_cnt   = bubble_cnt_q;
    assign flush_cnt    = flush_cnt_q;
endmodule

// File: tb/tb_stage_latch_hs.sv
module tb_stage_latch_hs;
    localparam int DW_A  = 96;
    localparam int DW_B  = 16;
    localparam int CW    = 9;
    localparam int CNT_B = 4;
    localparam int MAX_A = 65535;
    localparam int MAX_B = 15;

    logic stg_clk = 1'b0;
    logic reset;
    always #5 stg_clk = ~stg_clk;

    stage_latch_hs_if #(.DATA_W(DW_A), .CTRL_W(CW)) a_if ();
    stage_latch_hs_if #(.DATA_W(DW_B), .CTRL_W(CW)) b_if ();

    logic             a_flush, a_cnt_clr, b_flush, b_cnt_clr;
    logic [15:0]      a_stall, a_bubble, a_flushc;
    logic [CNT_B-1:0] b_stall, b_bubble, b_flushc;

    stage_latch_hs #(.DATA_W(DW_A), .CTRL_W(CW), .SKID(1), .CLR_DATA(1), .CNT_W(16)) u_a (
        .stg_clk(stg_clk), .reset(reset), .hs(a_if.slave), .flush(a_flush), .cnt_clr(a_cnt_clr),
        .stall_cnt(a_stall), .bubble_cnt(a_bubble), .flush_cnt(a_flushc));

    stage_latch_hs #(.DATA_W(DW_B), .CTRL_W(CW), .SKID(0), .CLR_DATA(0), .CNT_W(CNT_B)) u_b (
        .stg_clk(stg_clk), .reset(reset), .hs(b_if.slave), .flush(b_flush), .cnt_clr(b_cnt_clr),
        .stall_cnt(b_stall), .bubble_cnt(b_bubble), .flush_cnt(b_flushc));

    // Reference model: each stage is a bounded queue of entries plus plain integer counters
    typedef struct packed {
        logic [CW-1:0]   c;
        logic [DW_A-1:0] d;
    } ent_t;

    ent_t qa[$];
    ent_t qb[$];
    int ma_st, ma_bu, ma_fl, mb_st, mb_bu, mb_fl;
    int n_tests, n_fail;

    typedef struct {
        logic          iv;
        logic [7:0]    tag;
        logic [CW-1:0] ctrl;
        logic          ordy;
        logic          fl;
        logic          ev;
        logic [7:0]    etag;
        logic [CW-1:0] ectrl;
        logic          erdy;
        int            estall;
        int            eflush;
        logic          chk0;
    } vec_t;

    vec_t tbl [0:13];

    function automatic logic [DW_A-1:0] mk(input logic [7:0] tag);
        return {12{tag}};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_a();
        a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.in_ctrl = '0; a_if.out_ready = 1'b0;
        a_flush = 1'b0; a_cnt_clr = 1'b0;
    endtask

    task automatic idle_b();
        b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.in_ctrl = '0; b_if.out_ready = 1'b0;
        b_flush = 1'b0; b_cnt_clr = 1'b0;
    endtask

    // One cycle on the skid stage; starts and ends at a falling edge
    task automatic cyc_a(input logic iv, input logic [DW_A-1:0] d, input logic [CW-1:0] c,
                         input logic ordy, input logic fl, input logic clr);
        logic exp_rdy, acc, drn;
        ent_t e;
        a_if.in_valid = iv; a_if.in_data = d; a_if.in_ctrl = c; a_if.out_ready = ordy;
        a_flush = fl; a_cnt_clr = clr;
        #1;
        exp_rdy = (qa.size() < 2);
        chk("a_in_ready", a_if.in_ready, exp_rdy);
        acc = iv && exp_rdy;
        drn = (qa.size() > 0) && ordy;
        if (clr) begin
            ma_st = 0; ma_bu = 0; ma_fl = 0;
        end else begin
            if (qa.size() > 0 && !ordy && ma_st < MAX_A) ma_st++;
            if (qa.size() == 0 && ordy && ma_bu < MAX_A) ma_bu++;
            if (fl && ma_fl < MAX_A) ma_fl++;
        end
        if (fl) qa.delete();
        else begin
            if (drn) void'(qa.pop_front());
            if (acc) begin e.c = c; e.d = d; qa.push_back(e); end
        end
        @(posedge stg_clk);
        @(negedge stg_clk);
        chk("a_out_valid", a_if.out_valid, qa.size() > 0);
        chk("a_out_ctrl", a_if.out_ctrl, (qa.size() > 0) ? qa[0].c : '0);
        if (qa.size() > 0) chk("a_out_data", a_if.out_data, qa[0].d);
        chk("a_stall_cnt", a_stall, ma_st);
        chk("a_bubble_cnt", a_bubble, ma_bu);
        chk("a_flush_cnt", a_flushc, ma_fl);
    endtask

    // One cycle on the skid-less stage; starts and ends at a falling edge
    task automatic cyc_b(input logic iv, input logic [DW_B-1:0] d, input logic [CW-1:0] c,
                         input logic ordy, input logic fl, input logic clr);
        logic exp_rdy, acc, drn;
        ent_t e;
        b_if.in_valid = iv; b_if.in_data = d; b_if.in_ctrl = c; b_if.out_ready = ordy;
        b_flush = fl; b_cnt_clr = clr;
        #1;
        exp_rdy = (qb.size() == 0) || ordy;
        chk("b_in_ready", b_if.in_ready, exp_rdy);
        acc = iv && exp_rdy;
        drn = (qb.size() > 0) && ordy;
        if (clr) begin
            mb_st = 0; mb_bu = 0; mb_fl = 0;
        end else begin
            if (qb.size() > 0 && !ordy && mb_st < MAX_B) mb_st++;
            if (qb.size() == 0 && ordy && mb_bu < MAX_B) mb_bu++;
            if (fl && mb_fl < MAX_B) mb_fl++;
        end
        if (fl) qb.delete();
        else begin
            if (drn) void'(qb.pop_front());
            if (acc) begin e.c = c; e.d = {{(DW_A-DW_B){1'b0}}, d}; qb.push_back(e); end
        end
        @(posedge stg_clk);
        @(negedge stg_clk);
        chk("b_out_valid", b_if.out_valid, qb.size() > 0);
        chk("b_out_ctrl", b_if.out_ctrl, (qb.size() > 0) ? qb[0].c : '0);
        if (qb.size() > 0) chk("b_out_data", b_if.out_data, qb[0].d[DW_B-1:0]);
        chk("b_stall_cnt", b_stall, mb_st);
        chk("b_bubble_cnt", b_bubble, mb_bu);
        chk("b_flush_cnt", b_flushc, mb_fl);
    endtask

    initial begin
        int got;
        logic [7:0] t;
        logic [DW_B-1:0] held;
        n_tests = 0; n_fail = 0;
        ma_st = 0; ma_bu = 0; ma_fl = 0; mb_st = 0; mb_bu = 0; mb_fl = 0;
        idle_a(); idle_b();
        reset = 1'b1;
        repeat (2) @(negedge stg_clk);
        chk("rst_a_valid", a_if.out_valid, 0);
        chk("rst_a_ctrl", a_if.out_ctrl, 0);
        chk("rst_a_data", a_if.out_data, 0);
        chk("rst_a_ready", a_if.in_ready, 1);
        chk("rst_a_cnts", {a_stall, a_bubble, a_flushc}, 0);
        chk("rst_b_valid", b_if.out_valid, 0);
        chk("rst_b_data", b_if.out_data, 0);
        chk("rst_b_cnts", {b_stall, b_bubble, b_flushc}, 0);
        reset = 1'b0;

        // Single transfer, back-pressure into the skid, flush in SKID_FULL and in FULL with an accept
        tbl[0]  = '{1'b1, 8'hA5, 9'h1FF, 1'b1, 1'b0,  1'b1, 8'hA5, 9'h1FF, 1'b1, 0, 0, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 9'h000, 1'b1, 1'b0,  1'b0, 8'h00, 9'h000, 1'b1, 0, 0, 1'b0};
        tbl[2]  = '{1'b1, 8'h01, 9'h101, 1'b0, 1'b0,  1'b1, 8'h01, 9'h101, 1'b1, 0, 0, 1'b0};
        tbl[3]  = '{1'b1, 8'h02, 9'h102, 1'b0, 1'b0,  1'b1, 8'h01, 9'h101, 1'b0, 1, 0, 1'b0};
        tbl[4]  = '{1'b1, 8'h03, 9'h103, 1'b0, 1'b0,  1'b1, 8'h01, 9'h101, 1'b0, 2, 0, 1'b0};
        tbl[5]  = '{1'b1, 8'h03, 9'h103, 1'b1, 1'b0,  1'b1, 8'h02, 9'h102, 1'b1, 2, 0, 1'b0};
        tbl[6]  = '{1'b1, 8'h03, 9'h103, 1'b1, 1'b0,  1'b1, 8'h03, 9'h103, 1'b1, 2, 0, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 9'h000, 1'b1, 1'b0,  1'b0, 8'h00, 9'h000, 1'b1, 2, 0, 1'b0};
        tbl[8]  = '{1'b1, 8'h05, 9'h105, 1'b0, 1'b0,  1'b1, 8'h05, 9'h105, 1'b1, 2, 0, 1'b0};
        tbl[9]  = '{1'b1, 8'h06, 9'h106, 1'b0, 1'b0,  1'b1, 8'h05, 9'h105, 1'b0, 3, 0, 1'b0};
        tbl[10] = '{1'b1, 8'h04, 9'h104, 1'b0, 1'b1,  1'b0, 8'h00, 9'h000, 1'b1, 4, 1, 1'b1};
        tbl[11] = '{1'b1, 8'h07, 9'h107, 1'b0, 1'b0,  1'b1, 8'h07, 9'h107, 1'b1, 4, 1, 1'b0};
        tbl[12] = '{1'b1, 8'h08, 9'h108, 1'b0, 1'b1,  1'b0, 8'h00, 9'h000, 1'b1, 5, 2, 1'b1};
        tbl[13] = '{1'b0, 8'h00, 9'h000, 1'b1, 1'b0,  1'b0, 8'h00, 9'h000, 1'b1, 5, 2, 1'b0};
        @(negedge stg_clk);
        for (int i = 0; i < 14; i++) begin
            cyc_a(tbl[i].iv, mk(tbl[i].tag), tbl[i].ctrl, tbl[i].ordy, tbl[i].fl, 1'b0);
            chk("tbl_valid", a_if.out_valid, tbl[i].ev);
            chk("tbl_ctrl", a_if.out_ctrl, tbl[i].ectrl);
            if (tbl[i].ev) chk("tbl_data", a_if.out_data, mk(tbl[i].etag));
            if (tbl[i].chk0) chk("tbl_flush_data0", a_if.out_data, 0);
            chk("tbl_in_ready", a_if.in_ready, tbl[i].erdy);
            chk("tbl_stall", a_stall, tbl[i].estall);
            chk("tbl_flush_cnt", a_flushc, tbl[i].eflush);
        end

        // Full throughput: one entry per cycle, never stalled
        cyc_a(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            t = 8'(i + 16);
            cyc_a(1'b1, mk(t), {1'b1, t}, 1'b1, 1'b0, 1'b0);
            if (a_if.out_valid && a_if.out_data == mk(t)) got++;
        end
        cyc_a(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("thru_outputs", got, 20);
        chk("thru_stall", a_stall, 0);

        // Random traffic on the skid stage
        for (int i = 0; i < 400; i++) begin
            cyc_a($urandom_range(0, 3) != 0, {$urandom(), $urandom(), $urandom()}, 9'($urandom()),
                  1'($urandom()), $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
        end
        idle_a();

        // Counter saturation at CNT_W=4, then clear
        for (int i = 0; i < 20; i++) cyc_b(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("b_bubble_sat", b_bubble, 15);
        cyc_b(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        chk("b_bubble_clr", b_bubble, 0);

        // Flush without data clearing keeps the payload but kills valid and ctrl
        cyc_b(1'b1, 16'h1234, 9'h155, 1'b0, 1'b0, 1'b0);
        cyc_b(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        chk("b_flush_valid", b_if.out_valid, 0);
        chk("b_flush_ctrl", b_if.out_ctrl, 0);
        chk("b_flush_data_hold", b_if.out_data, 16'h1234);

        // Streaming with out_ready toggling every cycle
        for (int i = 0; i < 40; i++) begin
            cyc_b(1'b1, 16'(16'h0100 + i), 9'(9'h100 + i), 1'(i & 1), 1'b0, 1'b0);
        end
        cyc_b(1'b1, 16'h0777, 9'h077, 1'b0, 1'b0, 1'b0);
        held = b_if.out_data;

        // Reset mid-stream empties everything at once, before any clock edge
        reset = 1'b1;
        #1;
        chk("mid_rst_b_valid", b_if.out_valid, 0);
        chk("mid_rst_b_ctrl", b_if.out_ctrl, 0);
        chk("mid_rst_b_data", b_if.out_data, 0);
        chk("mid_rst_b_stall", b_stall, 0);
        chk("mid_rst_b_ready", b_if.in_ready, 1);
        qa.delete(); qb.delete();
        ma_st = 0; ma_bu = 0; ma_fl = 0; mb_st = 0; mb_bu = 0; mb_fl = 0;
        @(negedge stg_clk);
        reset = 1'b0;
        cyc_b(1'b1, 16'hBEEF, 9'h1AA, 1'b0, 1'b0, 1'b0);
        chk("post_rst_first", b_if.out_data, 16'hBEEF);
        chk("post_rst_not_old", b_if.out_data == held, 0);

        // Random traffic on the skid-less stage
        for (int i = 0; i < 300; i++) begin
            cyc_b($urandom_range(0, 3) != 0, 16'($urandom()), 9'($urandom()),
                  1'($urandom()), $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
